// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I opcodes, load/store funct3 encodings and memory-stage FSM states
package rv_pkg;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BCC   = 7'b1100011;
  localparam logic [6:0] LCC   = 7'b0000011;
  localparam logic [6:0] SCC   = 7'b0100011;
  localparam logic [6:0] MCC   = 7'b0010011;
  localparam logic [6:0] RCC   = 7'b0110011;
  localparam logic [6:0] SYS   = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  function automatic logic opc_writes_rd(input logic [6:0] opc);
    case (opc)
      LUI, AUIPC, JAL, JALR, MCC, RCC, LCC: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts the read word down to the addressed byte and sign/zero extends it
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] datai_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = datai_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access stage: DRD/DWR/DACK bus handshake, stall and MEM_WB register
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN
module mem_access
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_inst,
  input  logic [31:0] EX_MEM_alu,
  input  logic [31:0] EX_MEM_rs2,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_is_load,
  input  logic        EX_MEM_is_store,
  input  logic        EX_MEM_is_jal,
  input  logic        EX_MEM_is_jalr,
  input  logic [31:0] DATAI,
  input  logic        DACK,
  output logic [31:0] DADDR,
  output logic [31:0] DATAO,
  output logic [3:0]  BE,
  output logic        DRD,
  output logic        DWR,
  output logic        STALL,
  output logic        BUS_ERR,
  output logic        MISALIGN,
  output logic [31:0] MEM_WB_inst,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_data,
  output logic        MEM_WB_we
);

  mem_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] daddr_q, datao_q, wb_inst_q, wb_data_q;
  logic [3:0]  be_q;
  logic        drd_q, dwr_q, misalign_q, wb_we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  wb_rd_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        mem_op, misalign_c, issue, busy, timeout;
  logic [3:0]  be_d;
  logic [31:0] datao_d, pt_data_d, load_data;
  logic        pt_we_d;

  assign opcode  = EX_MEM_inst[6:0];
  assign funct3  = EX_MEM_inst[14:12];
  assign off     = EX_MEM_alu[1:0];
  assign mem_op  = (EX_MEM_is_load | EX_MEM_is_store) && (EX_MEM_inst != 32'h0);
  assign busy    = (state_q == ST_BUSY);
  assign timeout = busy && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign issue   = !busy && mem_op && !misalign_c;

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    if (mem_op) begin
      case (funct3[1:0])
        2'b01:   misalign_c = off[0];
        2'b10:   misalign_c = (off != 2'b00);
        default: misalign_c = 1'b0;
      endcase
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Loads read the whole word; lane selection happens on the return path.
  always_comb begin
    be_d    = 4'b1111;
    datao_d = 32'h0;
    if (!EX_MEM_is_load) begin
      case (funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          datao_d = {4{EX_MEM_rs2[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {off[1], 1'b0};
          datao_d = {2{EX_MEM_rs2[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          datao_d = EX_MEM_rs2;
        end
      endcase
    end
  end

  assign pt_data_d = (EX_MEM_is_jal | EX_MEM_is_jalr) ? (EX_MEM_pc + 32'd4) : EX_MEM_alu;
  assign pt_we_d   = (EX_MEM_rd != 5'd0) && opc_writes_rd(opcode);

  load_align u_load_align (
    .datai_i  (DATAI),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  // MEM_WB defaults to a bubble; only pass-through and load completion overwrite it.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'h0;
      daddr_q    <= 32'h0;
      datao_q    <= 32'h0;
      be_q       <= 4'h0;
      drd_q      <= 1'b0;
      dwr_q      <= 1'b0;
      f3_q       <= 3'h0;
      off_q      <= 2'h0;
      misalign_q <= 1'b0;
      wb_inst_q  <= 32'h0;
      wb_rd_q    <= 5'h0;
      wb_data_q  <= 32'h0;
      wb_we_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      wb_inst_q  <= 32'h0;
      wb_rd_q    <= 5'h0;
      wb_data_q  <= 32'h0;
      wb_we_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            daddr_q <= {EX_MEM_alu[31:2], 2'b00};
            be_q    <= be_d;
            datao_q <= datao_d;
            f3_q    <= funct3;
            off_q   <= off;
            drd_q   <= EX_MEM_is_load;
            dwr_q   <= !EX_MEM_is_load;
            cnt_q   <= 8'h0;
            state_q <= ST_BUSY;
          end else if (mem_op) begin
            misalign_q <= 1'b1;
          end else begin
            wb_inst_q <= EX_MEM_inst;
            wb_rd_q   <= EX_MEM_rd;
            wb_data_q <= pt_data_d;
            wb_we_q   <= pt_we_d;
          end
        end
        ST_BUSY: begin
          if (DACK) begin
            drd_q   <= 1'b0;
            dwr_q   <= 1'b0;
            state_q <= ST_IDLE;
            if (drd_q) begin
              wb_inst_q <= EX_MEM_inst;
              wb_rd_q   <= EX_MEM_rd;
              wb_data_q <= load_data;
              wb_we_q   <= (EX_MEM_rd != 5'd0);
            end
          end else if (timeout) begin
            drd_q   <= 1'b0;
            dwr_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DADDR       = daddr_q;
  assign DATAO       = datao_q;
  assign BE          = be_q;
  assign DRD         = drd_q;
  assign DWR         = dwr_q;
  assign MISALIGN    = misalign_q;
  assign STALL       = RES & (issue | (busy & ~DACK & ~timeout));
  assign BUS_ERR     = busy & timeout & ~DACK;
  assign MEM_WB_inst = wb_inst_q;
  assign MEM_WB_rd   = wb_rd_q;
  assign MEM_WB_data = wb_data_q;
  assign MEM_WB_we   = wb_we_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage RV32I pipeline, sitting between the execute stage's EX_MEM register and the register file writeback. It turns EX_MEM load and store requests into requests on the data bus, which uses a DRD/DWR/DACK handshake. It aligns store data to byte lanes, extracts and extends load data, and raises a pipeline stall while a bus access is outstanding. Non-memory instructions pass through to a registered MEM_WB stage unchanged.

## Interface
- TIMEOUT_CYCLES, 255: number of BUSY cycles without DACK before the access is aborted; 1..255.
- CLK  in  1  pipeline clock; every register updates on its rising edge.
- RES  in  1  reset, asynchronous, active-low.
- EX_MEM_pc  in  32  pc of the instruction in EX_MEM.
- EX_MEM_inst  in  32  instruction word; 0 = bubble.
- EX_MEM_alu  in  32  ALU result; this is the effective address for loads and stores.
- EX_MEM_rs2  in  32  store data.
- EX_MEM_rd  in  5  destination register.
- EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_jal, EX_MEM_is_jalr  in  1 each  decoded class flags.
- DATAI  in  32  read data bus.
- DACK  in  1  bus acknowledge; DATAI is valid in the same cycle.
- DADDR  out  32  bus address, word-aligned: {alu[31:2],2'b00}.
- DATAO  out  32  write data, lane-replicated.
- BE  out  4  byte enables.
- DRD, DWR  out  1 each  read and write request strobes.
- STALL  out  1  freezes PC, IF/ID, ID/EX and EX_MEM.
- BUS_ERR  out  1  one-cycle pulse on timeout.
- MISALIGN  out  1  one-cycle pulse on a misaligned access (see Configuration).
- MEM_WB_inst  out  32  registered instruction.
- MEM_WB_rd  out  5  registered destination register.
- MEM_WB_data  out  32  registered writeback value.
- MEM_WB_we  out  1  registered writeback enable.

## Operation
- FSM states: IDLE and BUSY.
- IDLE, memory op (load/store flag set, inst≠0, aligned):
  - register DADDR, BE, DATAO, funct3 and byte offset;
  - assert DRD or DWR;
  - clear the timeout counter;
  - go to BUSY.
- BUSY: hold all bus outputs stable and increment the counter.
  - DACK=1: drop the strobes, write MEM_WB, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES: drop the strobes, pulse BUS_ERR, write a bubble to MEM_WB, go to IDLE.
- Store lanes:
  - SB: BE=4'b0001<<off, DATAO={4{rs2[7:0]}}.
  - SH: BE=4'b0011<<{off[1],0}, DATAO={2{rs2[15:0]}}.
  - SW: BE=4'b1111, DATAO=rs2.
- Load lanes: BE=4'b1111. The data path is DATAI>>(off*8), then:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass.
- Pass-through, every non-memory, non-stalled cycle, registered at the next edge:
  - MEM_WB_data = pc+4 for JAL/JALR, otherwise alu.
  - MEM_WB_we = (rd≠0) and opcode ∈ {LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD}.
  - A store or branch gives we=0. A bubble gives inst=0, we=0.
- Load writeback: MEM_WB_we = (rd≠0). A store writes a bubble to MEM_WB.
- STALL = (IDLE & memory op present & aligned) | (BUSY & ~DACK & ~timeout).
- EX_MEM is held by STALL, so its contents stay valid for the whole access.

## Timing
- Reset (RES low, asynchronous):
  - FSM to IDLE, counter 0;
  - DRD, DWR, BUS_ERR, MISALIGN, STALL = 0;
  - BE=0, DADDR=0, DATAO=0;
  - MEM_WB_* = 0.
- Reset in BUSY aborts the access immediately, with no retry.
- Zero-wait-state bus (DACK high in the first BUSY cycle): 2 cycles per memory op and 1 stall cycle. Each extra wait cycle adds one stall cycle.
- Non-memory ops: 1-cycle latency, no stall.
- Back-to-back memory ops: the second op is detected in the IDLE cycle right after completion, so there are no idle bus cycles beyond that.
- DACK in IDLE is ignored.
- DACK and timeout in the same cycle: DACK wins and no error is raised.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - Misaligned cases: LH/LHU/SH with alu[0]=1; LW/SW with alu[1:0]≠0.
  - These issue no bus access, pulse MISALIGN for one cycle, write a bubble to MEM_WB, and raise no stall.
- MEM_MISALIGN_CHECK_EN undefined:
  - MISALIGN is tied 0.
  - The access proceeds using off as given; lanes shifted past bit 3 are truncated.

## Structure
- Shared package rv_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC, SYS);
  - funct3 load/store encodings;
  - the FSM state enum.
- One sub-module, load_align: combinational (DATAI, off, funct3) → extended 32-bit value.

## Test plan
- SW alu=0x100, rs2=0xDEADBEEF, DACK on the 1st BUSY cycle → DADDR=0x100, BE=1111, DWR 1 cycle, STALL 1 cycle, MEM_WB_we=0.
- SB alu=0x103, rs2=0x000000A5 → BE=1000, DATAO=0xA5A5A5A5.
- LB alu=0x201, DATAI=0x0000F000, DACK after 3 wait cycles → STALL 4 cycles, MEM_WB_data=0xFFFFFFF0. Same access with LBU → 0x000000F0.
- LW with DACK never asserted, TIMEOUT_CYCLES=4 → BUS_ERR pulses on the 4th BUSY cycle, MEM_WB_we=0, FSM in IDLE.
- With MEM_MISALIGN_CHECK_EN, LW alu=0x102 → no DRD, MISALIGN=1 for 1 cycle, STALL=0.
- RES low mid-BUSY → DRD=0 immediately, outputs at reset values. After release, ADDI x5 with alu=7 → MEM_WB_data=7, we=1 one cycle later.
